// File: rtl/dmem_arbiter_if.sv
// Data-memory arbiter bus: retired-store path, load request, memory port, writeback.
// slave = arbiter side, master = core/memory side.
interface dmem_arbiter_if;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_half;
  logic        st_full;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [2:0]  ld_func3;
  logic [6:0]  ld_pd;
  logic [4:0]  ld_rob;
  logic        ld_ready;
  logic        flush;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [6:0]  wb_pd;
  logic [4:0]  wb_rob;

  modport slave (
    input  st_valid, st_addr, st_data, st_half, ld_valid, ld_addr, ld_func3, ld_pd, ld_rob,
           flush, mem_gnt, mem_rvalid, mem_rdata,
    output st_full, ld_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           wb_valid, wb_data, wb_pd, wb_rob
  );

  modport master (
    output st_valid, st_addr, st_data, st_half, ld_valid, ld_addr, ld_func3, ld_pd, ld_rob,
           flush, mem_gnt, mem_rvalid, mem_rdata,
    input  st_full, ld_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           wb_valid, wb_data, wb_pd, wb_rob
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: 4-entry retired-store FIFO plus one load, one memory
// transaction in flight. Stores take priority over loads; a load that overlaps
// any buffered store word is held off.
// Optional macro DMEM_LOAD_AGING_EN: a waiting load wins after losing three
// arbitrations to stores.
module dmem_arbiter (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ST_REQ, LD_REQ, LD_WAIT} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        half;
  } st_entry_t;

  state_t      state, state_nxt;
  st_entry_t   fifo [4];
  st_entry_t   head;
  logic [1:0]  rd_ptr, wr_ptr;
  logic [2:0]  count;
  logic [3:0][1:0] slot_off;
  logic        enq, deq, hazard, load_cand, store_wins, ld_accept;

  logic [31:0] lq_addr;
  logic [2:0]  lq_func3;
  logic [6:0]  lq_pd;
  logic [4:0]  lq_rob;
  logic        killed;

  logic        mem_req_c, mem_we_c;
  logic [31:0] mem_addr_c, mem_wdata_c;
  logic [3:0]  mem_be_c;
  logic [7:0]  ld_byte;

  logic        wb_valid_q;
  logic [31:0] wb_data_q;
  logic [6:0]  wb_pd_q;
  logic [4:0]  wb_rob_q;

  assign head = fifo[rd_ptr];
  assign enq  = bus.st_valid && (count != 3'd4);

  // Hazard: any occupied slot holding the same word as the incoming load.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 4; i++) begin
      slot_off[i] = 2'(i) - rd_ptr;
      if (({1'b0, slot_off[i]} < count) && (fifo[i].addr[31:2] == bus.ld_addr[31:2]))
        hazard = 1'b1;
    end
  end

  assign load_cand = bus.ld_valid && !hazard && !bus.flush;

`ifdef DMEM_LOAD_AGING_EN
  logic [1:0] age;

  assign store_wins = (count != 3'd0) && !(load_cand && (age == 2'd3));

  // Age a hazard-free waiting load each time a store beats it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      age <= 2'd0;
    else if (ld_accept)
      age <= 2'd0;
    else if ((state == IDLE) && store_wins && load_cand && (age != 2'd3))
      age <= age + 2'd1;
  end
`else
  assign store_wins = (count != 3'd0);
`endif

  // Store payload storage; contents are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (enq) fifo[wr_ptr] <= '{addr: bus.st_addr, data: bus.st_data, half: bus.st_half};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 2'd1;
      if (deq) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, enq} - {2'b00, deq};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and memory-port drive; outputs depend only on state and held
  // registers so they stay stable until granted.
  always_comb begin
    state_nxt   = state;
    ld_accept   = 1'b0;
    deq         = 1'b0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = 32'd0;
    mem_wdata_c = 32'd0;
    mem_be_c    = 4'd0;
    case (state)
      IDLE: begin
        if (store_wins) begin
          state_nxt = ST_REQ;
        end else if (load_cand) begin
          ld_accept = 1'b1;
          state_nxt = LD_REQ;
        end
      end
      ST_REQ: begin
        mem_req_c  = 1'b1;
        mem_we_c   = 1'b1;
        mem_addr_c = head.addr;
        if (head.half) begin
          mem_wdata_c = {2{head.data[15:0]}};
          mem_be_c    = head.addr[1] ? 4'b1100 : 4'b0011;
        end else begin
          mem_wdata_c = head.data;
          mem_be_c    = 4'b1111;
        end
        if (bus.mem_gnt) begin
          deq       = 1'b1;
          state_nxt = IDLE;
        end
      end
      LD_REQ: begin
        mem_req_c  = 1'b1;
        mem_addr_c = {lq_addr[31:2], 2'b00};
        mem_be_c   = 4'b1111;
        if (bus.mem_gnt) state_nxt = LD_WAIT;
      end
      LD_WAIT: begin
        if (bus.mem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the accepted load; a flush while it is in flight kills its writeback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lq_addr  <= 32'd0;
      lq_func3 <= 3'd0;
      lq_pd    <= 7'd0;
      lq_rob   <= 5'd0;
      killed   <= 1'b0;
    end else if (ld_accept) begin
      lq_addr  <= bus.ld_addr;
      lq_func3 <= bus.ld_func3;
      lq_pd    <= bus.ld_pd;
      lq_rob   <= bus.ld_rob;
      killed   <= 1'b0;
    end else if (bus.flush && ((state == LD_REQ) || (state == LD_WAIT))) begin
      killed <= 1'b1;
    end
  end

  assign ld_byte = bus.mem_rdata[{lq_addr[1:0], 3'b000} +: 8];

  // Registered writeback, only for a live load's returning data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_data_q  <= 32'd0;
      wb_pd_q    <= 7'd0;
      wb_rob_q   <= 5'd0;
    end else begin
      wb_valid_q <= 1'b0;
      if ((state == LD_WAIT) && bus.mem_rvalid && !killed && !bus.flush) begin
        wb_valid_q <= 1'b1;
        wb_data_q  <= (lq_func3 == 3'b100) ? {24'd0, ld_byte} : bus.mem_rdata;
        wb_pd_q    <= lq_pd;
        wb_rob_q   <= lq_rob;
      end
    end
  end

  assign bus.st_full   = (count == 3'd4);
  assign bus.ld_ready  = ld_accept;
  assign bus.mem_req   = mem_req_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.mem_be    = mem_be_c;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_pd     = wb_pd_q;
  assign bus.wb_rob    = wb_rob_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: per-cycle directed vector table plus hand sequences
// for full FIFO, reset mid-load and load aging / strict priority.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if dif ();
  dmem_arbiter dut (.clk(clk), .reset(reset), .bus(dif));

  typedef struct {
    logic st_v; logic [31:0] st_a; logic [31:0] st_d; logic st_h;
    logic ld_v; logic [31:0] ld_a; logic [2:0] f3; logic [6:0] pd; logic [4:0] rob;
    logic fl; logic gnt; logic rv; logic [31:0] rd;
  } in_t;

  typedef struct {
    logic full; logic rdy; logic req; logic we;
    logic [31:0] a; logic [31:0] wd; logic [3:0] be;
    logic wbv; logic [31:0] wbd; logic [6:0] wpd; logic [4:0] wrob;
  } exp_t;

  typedef struct { in_t i; exp_t e; } vec_t;

  vec_t tbl[$];
  int n_tests = 0;
  int n_fail = 0;

  function automatic in_t nop();
    in_t x;
    x = '{default: '0};
    return x;
  endfunction
  function automatic in_t st(input logic [31:0] a, input logic [31:0] d, input logic h);
    in_t x = nop();
    x.st_v = 1'b1; x.st_a = a; x.st_d = d; x.st_h = h;
    return x;
  endfunction
  function automatic in_t ld(input logic [31:0] a, input logic [2:0] f3,
                             input logic [6:0] pd, input logic [4:0] rob);
    in_t x = nop();
    x.ld_v = 1'b1; x.ld_a = a; x.f3 = f3; x.pd = pd; x.rob = rob;
    return x;
  endfunction
  function automatic in_t with_bus(input in_t x0, input logic fl, input logic g);
    in_t x = x0;
    x.fl = fl; x.gnt = g;
    return x;
  endfunction
  function automatic in_t rv(input logic [31:0] d);
    in_t x = nop();
    x.rv = 1'b1; x.rd = d;
    return x;
  endfunction

  function automatic exp_t e(input logic full, input logic rdy);
    exp_t x;
    x = '{default: '0};
    x.full = full; x.rdy = rdy;
    return x;
  endfunction
  function automatic exp_t em(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] be);
    exp_t x = e(1'b0, 1'b0);
    x.req = 1'b1; x.we = we; x.a = a; x.wd = wd; x.be = be;
    return x;
  endfunction
  function automatic exp_t ewb(input logic [31:0] d, input logic [6:0] pd, input logic [4:0] rob);
    exp_t x = e(1'b0, 1'b0);
    x.wbv = 1'b1; x.wbd = d; x.wpd = pd; x.wrob = rob;
    return x;
  endfunction

  task automatic add(input in_t i, input exp_t x);
    vec_t v;
    v.i = i; v.e = x;
    tbl.push_back(v);
  endtask

  task automatic apply(input in_t x);
    dif.st_valid = x.st_v; dif.st_addr = x.st_a; dif.st_data = x.st_d; dif.st_half = x.st_h;
    dif.ld_valid = x.ld_v; dif.ld_addr = x.ld_a; dif.ld_func3 = x.f3;
    dif.ld_pd = x.pd; dif.ld_rob = x.rob;
    dif.flush = x.fl; dif.mem_gnt = x.gnt; dif.mem_rvalid = x.rv; dif.mem_rdata = x.rd;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, expv);
    end
  endtask

  task automatic chk_vec(input int k, input exp_t x);
    logic ok;
    ok = (dif.st_full === x.full) && (dif.ld_ready === x.rdy) &&
         (dif.mem_req === x.req) && (dif.wb_valid === x.wbv);
    if (x.req)
      ok = ok && (dif.mem_we === x.we) && (dif.mem_addr === x.a) &&
           (dif.mem_wdata === x.wd) && (dif.mem_be === x.be);
    if (x.wbv)
      ok = ok && (dif.wb_data === x.wbd) && (dif.wb_pd === x.wpd) && (dif.wb_rob === x.wrob);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL vec%0d got full=%b rdy=%b req=%b we=%b a=%h wd=%h be=%h wbv=%b wbd=%h pd=%h rob=%h expected full=%b rdy=%b req=%b we=%b a=%h wd=%h be=%h wbv=%b wbd=%h pd=%h rob=%h",
               k, dif.st_full, dif.ld_ready, dif.mem_req, dif.mem_we, dif.mem_addr, dif.mem_wdata,
               dif.mem_be, dif.wb_valid, dif.wb_data, dif.wb_pd, dif.wb_rob,
               x.full, x.rdy, x.req, x.we, x.a, x.wd, x.be, x.wbv, x.wbd, x.wpd, x.wrob);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];
    int arbs;
    int rdy_seen;

    apply(nop());

    // sw 0x100 granted on first request, then an lw proving the FIFO drained
    add(st(32'h100, 32'hDEADBEEF, 1'b0), e(0, 0));
    add(nop(), e(0, 0));
    add(with_bus(nop(), 0, 1), em(1, 32'h100, 32'hDEADBEEF, 4'hF));
    add(ld(32'h100, 3'b010, 7'd5, 5'd3), e(0, 1));
    add(with_bus(nop(), 0, 1), em(0, 32'h100, 32'h0, 4'hF));
    add(rv(32'hCAFEF00D), e(0, 0));
    add(nop(), ewb(32'hCAFEF00D, 7'd5, 5'd3));
    add(nop(), e(0, 0));
    // sh to upper half, held one cycle without grant
    add(st(32'h102, 32'h0000ABCD, 1'b1), e(0, 0));
    add(nop(), e(0, 0));
    add(nop(), em(1, 32'h102, 32'hABCDABCD, 4'hC));
    add(with_bus(nop(), 0, 1), em(1, 32'h102, 32'hABCDABCD, 4'hC));
    // lw behind a store to the same word
    add(st(32'h200, 32'h55AA55AA, 1'b0), e(0, 0));
    add(ld(32'h200, 3'b010, 7'h11, 5'd4), e(0, 0));
    add(ld(32'h200, 3'b010, 7'h11, 5'd4), em(1, 32'h200, 32'h55AA55AA, 4'hF));
    add(with_bus(ld(32'h200, 3'b010, 7'h11, 5'd4), 0, 1), em(1, 32'h200, 32'h55AA55AA, 4'hF));
    add(ld(32'h200, 3'b010, 7'h11, 5'd4), e(0, 1));
    add(with_bus(nop(), 0, 1), em(0, 32'h200, 32'h0, 4'hF));
    add(nop(), e(0, 0));
    add(rv(32'h01020304), e(0, 0));
    add(nop(), ewb(32'h01020304, 7'h11, 5'd4));
    // lbu byte 3 and byte 1
    add(ld(32'h303, 3'b100, 7'h2A, 5'h1F), e(0, 1));
    add(with_bus(nop(), 0, 1), em(0, 32'h300, 32'h0, 4'hF));
    add(rv(32'h11223344), e(0, 0));
    add(nop(), ewb(32'h00000011, 7'h2A, 5'h1F));
    add(ld(32'h301, 3'b100, 7'd1, 5'd2), e(0, 1));
    add(with_bus(nop(), 0, 1), em(0, 32'h300, 32'h0, 4'hF));
    add(rv(32'h11223344), e(0, 0));
    add(nop(), ewb(32'h00000033, 7'd1, 5'd2));
    // flush with ld_valid refuses; flush in LD_WAIT suppresses writeback
    add(with_bus(ld(32'h400, 3'b010, 7'd3, 5'd3), 1, 0), e(0, 0));
    add(ld(32'h400, 3'b010, 7'd3, 5'd3), e(0, 1));
    add(with_bus(nop(), 0, 1), em(0, 32'h400, 32'h0, 4'hF));
    add(with_bus(nop(), 1, 0), e(0, 0));
    add(rv(32'h12345678), e(0, 0));
    add(nop(), e(0, 0));
    // flush leaves the store path alone
    add(st(32'h500, 32'h0BADF00D, 1'b0), e(0, 0));
    add(with_bus(nop(), 1, 0), e(0, 0));
    add(with_bus(nop(), 1, 0), em(1, 32'h500, 32'h0BADF00D, 4'hF));
    add(with_bus(nop(), 0, 1), em(1, 32'h500, 32'h0BADF00D, 4'hF));
    add(nop(), e(0, 0));
    add(ld(32'h500, 3'b010, 7'd6, 5'd6), e(0, 1));
    add(with_bus(nop(), 0, 1), em(0, 32'h500, 32'h0, 4'hF));
    add(rv(32'hA5A5A5A5), e(0, 0));
    add(nop(), ewb(32'hA5A5A5A5, 7'd6, 5'd6));

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", {59'd0, dif.mem_req, dif.mem_we, dif.ld_ready, dif.wb_valid, dif.st_full}, 64'd0);
    chk("rst_addr_wd", {dif.mem_addr, dif.mem_wdata}, 64'd0);
    chk("rst_be_wb", {dif.mem_be, dif.wb_data, dif.wb_pd, dif.wb_rob}, 64'd0);
    reset = 1'b0;

    for (int k = 0; k < tbl.size(); k++) begin
      apply(tbl[k].i);
      #7;
      chk_vec(k, tbl[k].e);
      step();
    end
    apply(nop());

    // five stores with no grant: four buffered, fifth dropped
    for (int p = 0; p < 5; p++) begin
      apply(st(32'h600 + 32'(4 * p), 32'h1000 + 32'(p), 1'b0));
      #7;
      if (p == 3) chk("full_before4", {63'd0, dif.st_full}, 64'd0);
      if (p == 4) chk("full_after4", {63'd0, dif.st_full}, 64'd1);
      step();
    end
    apply(nop());
    dif.mem_gnt = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #7;
      if (dif.mem_req && dif.mem_we) begin
        wr_a.push_back(dif.mem_addr);
        wr_d.push_back(dif.mem_wdata);
      end
      step();
    end
    dif.mem_gnt = 1'b0;
    chk("full_nwrites", 64'(wr_a.size()), 64'd4);
    for (int w = 0; w < 4 && w < wr_a.size(); w++)
      chk($sformatf("full_wr%0d", w), {wr_a[w], wr_d[w]},
          {32'h600 + 32'(4 * w), 32'h1000 + 32'(w)});
    #7;
    chk("full_drained", {63'd0, dif.st_full}, 64'd0);
    step();

    // reset while a load waits for data; late rvalid ignored
    apply(ld(32'h700, 3'b010, 7'd9, 5'd9));
    #7;
    chk("rmid_accept", {63'd0, dif.ld_ready}, 64'd1);
    step();
    apply(with_bus(nop(), 0, 1));
    step();
    apply(nop());
    reset = 1'b1;
    #2;
    chk("rmid_rst_out", {dif.mem_req, dif.wb_valid, dif.wb_data, 30'd0}, 64'd0);
    step();
    reset = 1'b0;
    apply(rv(32'hFFFFFFFF));
    #7;
    chk("rmid_idle", {63'd0, dif.mem_req}, 64'd0);
    step();
    apply(nop());
    #7;
    chk("rmid_no_wb", {63'd0, dif.wb_valid}, 64'd0);
    step();

    // continuous stores against a waiting hazard-free load
    arbs = 0;
    rdy_seen = 0;
    dif.mem_gnt = 1'b1;
    dif.st_valid = 1'b1; dif.st_addr = 32'h900; dif.st_data = 32'h0; dif.st_half = 1'b0;
    step();
    dif.ld_valid = 1'b1; dif.ld_addr = 32'h800; dif.ld_func3 = 3'b010;
    dif.ld_pd = 7'd7; dif.ld_rob = 5'd7;
    for (int c = 1; c < 21; c++) begin
      dif.st_addr = 32'h900 + 32'(4 * c);
      #7;
      if (!dif.mem_req) arbs++;
      if (dif.ld_ready) begin
        rdy_seen++;
        break;
      end
      step();
    end
`ifdef DMEM_LOAD_AGING_EN
    chk("age_accepted", 64'(rdy_seen), 64'd1);
    chk("age_arb_num", 64'(arbs), 64'd4);
`else
    chk("strict_no_load", 64'(rdy_seen), 64'd0);
    chk("strict_arbs", 64'(arbs), 64'd10);
`endif
    step();
    apply(nop());
    dif.mem_gnt = 1'b1;
    dif.mem_rvalid = 1'b1;
    repeat (24) step();
    apply(nop());
    #7;
    chk("drain_empty", {62'd0, dif.st_full, dif.mem_req}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
